// File: rtl/bgr_startup_ctrl_pkg.sv
// Shared types and helpers for the bandgap start-up sequencer.
// State encodings are fixed because state_o is read by debug tooling.
package bgr_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_KICK   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_READY  = 3'd4,
    ST_FAULT  = 3'd5
  } bgr_state_t;

  // Cycle counter width: enough for the longest timed state, plus one spare bit.
  function automatic int calc_cw(input int pulse, input int settle, input int timeout);
    int m;
    m = pulse;
    if (settle > m) m = settle;
    if (timeout > m) m = timeout;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/bgr_startup_ctrl_sync2.sv
// Two-flop synchronizer for the asynchronous vbg_ok comparator flag.
// Both flops reset to 0 so the FSM never sees a stale "ok" after reset.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/bgr_startup_ctrl.sv
// Bandgap start-up sequencer: kicks the core, waits for settling, qualifies
// the filtered vbg_ok flag and re-kicks on brown-out.
//
// state  | meaning
// IDLE   | reference off, counters and retry budget cleared
// KICK   | porst held high for PULSE_CYCLES
// SETTLE | wait SETTLE_CYCLES for the loop to settle
// CHECK  | look for OK_FILTER consecutive ok samples, bounded by CHECK_TIMEOUT
// READY  | reference qualified, watching for brown-out
// FAULT  | retry budget exhausted, held until enable drops
module bgr_startup_ctrl
  import bgr_ctrl_pkg::*;
#(
  parameter int PULSE_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int OK_FILTER     = 3,
  parameter int CHECK_TIMEOUT = 16,
  parameter int MAX_RETRIES   = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable,
  input  logic                               vbg_ok,
  output logic                               porst,
  output logic                               ready,
  output logic                               fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
  output logic [2:0]                         state_o
);

  localparam int CW = calc_cw(PULSE_CYCLES, SETTLE_CYCLES, CHECK_TIMEOUT);
  localparam int FW = $clog2(OK_FILTER + 1);
  localparam int RW = $clog2(MAX_RETRIES + 1);

  localparam logic [CW-1:0] PULSE_LAST  = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CHECK_LAST  = CW'(CHECK_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX     = {CW{1'b1}};
  localparam logic [FW-1:0] FILT_LAST   = FW'(OK_FILTER - 1);
  localparam logic [FW-1:0] FILT_MAX    = {FW{1'b1}};
  localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

  bgr_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [FW-1:0] ok_cnt, ok_cnt_n;
  logic [FW-1:0] bad_cnt, bad_cnt_n;
  logic [RW-1:0] retry_n;
  logic          ok_s;

  sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (vbg_ok),
    .q   (ok_s)
  );

  always_comb begin
    state_n   = state;
    ok_cnt_n  = '0;
    bad_cnt_n = '0;
    retry_n   = retry_cnt;

    case (state)
      ST_IDLE: begin
        retry_n = '0;
        if (enable) state_n = ST_KICK;
      end
      ST_KICK: begin
        if (cnt == PULSE_LAST) state_n = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt == SETTLE_LAST) state_n = ST_CHECK;
      end
      ST_CHECK: begin
        if (ok_s) ok_cnt_n = (ok_cnt == FILT_MAX) ? ok_cnt : ok_cnt + 1'b1;
        // Qualification takes precedence over a coincident timeout.
        if (ok_s && ok_cnt == FILT_LAST) begin
          state_n = ST_READY;
        end else if (cnt == CHECK_LAST) begin
          if (retry_cnt < RETRY_MAX) begin
            retry_n = retry_cnt + 1'b1;
            state_n = ST_KICK;
          end else begin
            state_n = ST_FAULT;
          end
        end
      end
      ST_READY: begin
        if (!ok_s) bad_cnt_n = (bad_cnt == FILT_MAX) ? bad_cnt : bad_cnt + 1'b1;
        if (!ok_s && bad_cnt == FILT_LAST) begin
          retry_n = '0;
          state_n = ST_KICK;
        end
      end
      ST_FAULT: begin
        state_n = ST_FAULT;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    // Dropping enable aborts whatever is in progress, including a kick pulse.
    if (!enable && state != ST_IDLE) begin
      state_n   = ST_IDLE;
      ok_cnt_n  = '0;
      bad_cnt_n = '0;
      retry_n   = '0;
    end

    if (state_n == ST_IDLE || state_n != state) begin
      cnt_n = '0;
    end else begin
      cnt_n = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      ok_cnt    <= '0;
      bad_cnt   <= '0;
      retry_cnt <= '0;
      porst     <= 1'b0;
      ready     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      ok_cnt    <= ok_cnt_n;
      bad_cnt   <= bad_cnt_n;
      retry_cnt <= retry_n;
      porst     <= (state_n == ST_KICK);
      ready     <= (state_n == ST_READY);
      fault     <= (state_n == ST_FAULT);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_bgr_startup_ctrl.sv
// Self-checking bench for bgr_startup_ctrl: per-scenario tables of expected
// outputs at given edges, pushed to a scoreboard and checked as edges occur.
module tb_bgr_startup_ctrl;
  import bgr_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       vbg_ok;
  logic       porst;
  logic       ready;
  logic       fault;
  logic [1:0] retry_cnt;
  logic [2:0] state_o;

  always #5 clk = ~clk;

  bgr_startup_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .vbg_ok    (vbg_ok),
    .porst     (porst),
    .ready     (ready),
    .fault     (fault),
    .retry_cnt (retry_cnt),
    .state_o   (state_o)
  );

  typedef struct {
    int         e;
    logic [2:0] st;
    logic       p;
    logic       r;
    logic       f;
    logic [1:0] rt;
    logic       chk_rt;
  } exp_t;

  typedef struct {
    int   e;
    logic en;
    logic ok;
  } stim_t;

  exp_t  sb[$];
  stim_t sq[$];
  int    total = 0;
  int    bad   = 0;
  int    edge_n;
  string scen;

  exp_t nom_tbl [8];
  exp_t flt_tbl [15];
  exp_t gl_tbl  [5];
  exp_t bo_tbl  [8];
  exp_t ed_tbl  [3];
  exp_t rs_tbl  [6];

  function automatic exp_t mk(input int e, input logic [2:0] st, input logic p,
                              input logic r, input logic f, input logic [1:0] rt,
                              input logic c);
    exp_t x;
    x.e = e; x.st = st; x.p = p; x.r = r; x.f = f; x.rt = rt; x.chk_rt = c;
    return x;
  endfunction

  function automatic stim_t ms(input int e, input logic en, input logic ok);
    stim_t s;
    s.e = e; s.en = en; s.ok = ok;
    return s;
  endfunction

  task automatic check_now(input exp_t x);
    total++;
    if (state_o !== x.st || porst !== x.p || ready !== x.r || fault !== x.f ||
        (x.chk_rt && retry_cnt !== x.rt)) begin
      bad++;
      $display("FAIL %s edge %0d: got st=%0d porst=%b ready=%b fault=%b retry=%0d, want st=%0d porst=%b ready=%b fault=%b retry=%0d",
               scen, x.e, state_o, porst, ready, fault, retry_cnt,
               x.st, x.p, x.r, x.f, x.rt);
    end
  endtask

  task automatic compare_due();
    exp_t x;
    while (sb.size() > 0 && sb[0].e == edge_n) begin
      x = sb.pop_front();
      check_now(x);
    end
  endtask

  task automatic apply_due();
    stim_t s;
    while (sq.size() > 0 && sq[0].e == edge_n) begin
      s = sq.pop_front();
      enable = s.en;
      vbg_ok = s.ok;
    end
  endtask

  // Edge 0 is "now"; expectations are checked before stimulus for that edge is applied.
  task automatic run(input int budget);
    edge_n = 0;
    compare_due();
    apply_due();
    while ((sb.size() > 0 || sq.size() > 0) && edge_n < budget) begin
      @(posedge clk);
      #1;
      edge_n++;
      compare_due();
      apply_due();
    end
    if (sb.size() > 0 || sq.size() > 0) begin
      total++;
      bad++;
      $display("FAIL %s timeout: got %0d pending entries at edge %0d, want 0",
               scen, sb.size() + sq.size(), edge_n);
      sb.delete();
      sq.delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    nom_tbl = '{mk(0, ST_IDLE, 0,0,0,0,1), mk(1, ST_KICK, 1,0,0,0,1),
                mk(4, ST_KICK, 1,0,0,0,1), mk(5, ST_SETTLE, 0,0,0,0,1),
                mk(12, ST_SETTLE, 0,0,0,0,1), mk(13, ST_CHECK, 0,0,0,0,1),
                mk(15, ST_CHECK, 0,0,0,0,1), mk(16, ST_READY, 0,1,0,0,1)};
    flt_tbl = '{mk(0, ST_IDLE, 0,0,0,0,1), mk(1, ST_KICK, 1,0,0,0,1),
                mk(4, ST_KICK, 1,0,0,0,1), mk(5, ST_SETTLE, 0,0,0,0,1),
                mk(13, ST_CHECK, 0,0,0,0,1), mk(28, ST_CHECK, 0,0,0,0,1),
                mk(29, ST_KICK, 1,0,0,1,1), mk(32, ST_KICK, 1,0,0,1,1),
                mk(33, ST_SETTLE, 0,0,0,1,1), mk(57, ST_KICK, 1,0,0,2,1),
                mk(84, ST_CHECK, 0,0,0,2,1), mk(85, ST_FAULT, 0,0,1,2,1),
                mk(95, ST_FAULT, 0,0,1,2,1), mk(96, ST_IDLE, 0,0,0,0,0),
                mk(97, ST_IDLE, 0,0,0,0,1)};
    gl_tbl  = '{mk(13, ST_CHECK, 0,0,0,0,1), mk(15, ST_CHECK, 0,0,0,0,1),
                mk(16, ST_CHECK, 0,0,0,0,1), mk(18, ST_CHECK, 0,0,0,0,1),
                mk(19, ST_READY, 0,1,0,0,1)};
    bo_tbl  = '{mk(16, ST_READY, 0,1,0,0,1), mk(24, ST_READY, 0,1,0,0,1),
                mk(26, ST_READY, 0,1,0,0,1), mk(34, ST_READY, 0,1,0,0,1),
                mk(35, ST_KICK, 1,0,0,0,1), mk(38, ST_KICK, 1,0,0,0,1),
                mk(39, ST_SETTLE, 0,0,0,0,1), mk(41, ST_IDLE, 0,0,0,0,1)};
    ed_tbl  = '{mk(1, ST_KICK, 1,0,0,0,1), mk(2, ST_KICK, 1,0,0,0,1),
                mk(3, ST_IDLE, 0,0,0,0,1)};
    rs_tbl  = '{mk(0, ST_IDLE, 0,0,0,0,1), mk(1, ST_KICK, 1,0,0,0,1),
                mk(4, ST_KICK, 1,0,0,0,1), mk(5, ST_SETTLE, 0,0,0,0,1),
                mk(13, ST_CHECK, 0,0,0,0,1), mk(16, ST_READY, 0,1,0,0,1)};

    // Reset holds everything low even with enable requested.
    scen = "reset";
    rst = 1'b1; enable = 1'b1; vbg_ok = 1'b1;
    idle(3);
    check_now(mk(0, ST_IDLE, 0,0,0,0,1));
    enable = 1'b0;
    rst = 1'b0;
    idle(4);

    scen = "nominal";
    foreach (nom_tbl[i]) sb.push_back(nom_tbl[i]);
    sq.push_back(ms(0, 1'b1, 1'b1));
    run(200);
    enable = 1'b0; vbg_ok = 1'b0;
    idle(4);

    scen = "fault";
    foreach (flt_tbl[i]) sb.push_back(flt_tbl[i]);
    sq.push_back(ms(0, 1'b1, 1'b0));
    sq.push_back(ms(95, 1'b0, 1'b0));
    run(200);
    vbg_ok = 1'b1;
    idle(4);

    scen = "glitch";
    foreach (gl_tbl[i]) sb.push_back(gl_tbl[i]);
    sq.push_back(ms(0, 1'b1, 1'b1));
    sq.push_back(ms(13, 1'b1, 1'b0));
    sq.push_back(ms(14, 1'b1, 1'b1));
    run(200);
    enable = 1'b0;
    idle(4);

    scen = "brownout";
    foreach (bo_tbl[i]) sb.push_back(bo_tbl[i]);
    sq.push_back(ms(0, 1'b1, 1'b1));
    sq.push_back(ms(20, 1'b1, 1'b0));
    sq.push_back(ms(22, 1'b1, 1'b1));
    sq.push_back(ms(30, 1'b1, 1'b0));
    sq.push_back(ms(34, 1'b1, 1'b1));
    sq.push_back(ms(40, 1'b0, 1'b1));
    run(200);
    idle(4);

    scen = "enable_drop";
    foreach (ed_tbl[i]) sb.push_back(ed_tbl[i]);
    sq.push_back(ms(0, 1'b1, 1'b1));
    sq.push_back(ms(2, 1'b0, 1'b1));
    run(200);
    idle(4);

    // Get into SETTLE, then pulse rst between edges.
    scen = "pre_rst";
    sb.push_back(mk(7, ST_SETTLE, 0,0,0,0,1));
    sq.push_back(ms(0, 1'b1, 1'b1));
    run(200);
    #2;
    rst = 1'b1;
    #1;
    scen = "async_rst";
    check_now(mk(0, ST_IDLE, 0,0,0,0,1));
    #1;
    rst = 1'b0;

    scen = "post_rst";
    foreach (rs_tbl[i]) sb.push_back(rs_tbl[i]);
    run(200);
    enable = 1'b0;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
